// File: rtl/fb_scanout.sv
`default_nettype none
// ============================================================================
// Module   : fb_scanout
// Brief    : Framebuffer scanout reader. Prefetches packed 8-bit palette
//            indices into a 64-bit word FIFO and emits a pixel stream with
//            480p-style sync/blank timing on a pixel clock enable.
// Option   : FB_SCANOUT_TESTPAT_EN adds the hc^vc test pattern on test_pat.
// Revision : 1.0  initial release
// ============================================================================
module fb_scanout #(
   parameter int H_ACTIVE   = 720,
   parameter int V_ACTIVE   = 480,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 62,
   parameter int H_BP       = 60,
   parameter int V_FP       = 9,
   parameter int V_SYNC     = 6,
   parameter int V_BP       = 30,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ce_pix,
   output logic [27:0] fb_addr,
   output logic        fb_req,
   input  logic        fb_ready,
   input  logic [63:0] fb_rdata,
   input  logic        test_pat,
   output logic [7:0]  color,
   output logic        de,
   output logic        hs,
   output logic        vs,
   output logic        frame_start,
   output logic        underflow
);

   localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int c_WORDS   = (H_ACTIVE * V_ACTIVE) / 8;
   localparam int c_HW      = ($clog2(c_H_TOTAL) > 8) ? $clog2(c_H_TOTAL) : 8;
   localparam int c_VW      = ($clog2(c_V_TOTAL) > 8) ? $clog2(c_V_TOTAL) : 8;
   localparam int c_WLW     = $clog2(c_WORDS + 1);
   localparam int c_AW      = $clog2(FIFO_DEPTH);

   localparam logic [c_HW-1:0]  c_H_LAST  = c_HW'(c_H_TOTAL - 1);
   localparam logic [c_VW-1:0]  c_V_LAST  = c_VW'(c_V_TOTAL - 1);
   localparam logic [c_HW-1:0]  c_H_ACT   = c_HW'(H_ACTIVE);
   localparam logic [c_VW-1:0]  c_V_ACT   = c_VW'(V_ACTIVE);
   localparam logic [c_HW-1:0]  c_HS_BEG  = c_HW'(H_ACTIVE + H_FP);
   localparam logic [c_HW-1:0]  c_HS_END  = c_HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [c_VW-1:0]  c_VS_BEG  = c_VW'(V_ACTIVE + V_FP);
   localparam logic [c_VW-1:0]  c_VS_END  = c_VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [c_WLW-1:0] c_WORDS_L = c_WLW'(c_WORDS);
   localparam logic [c_AW:0]    c_FULL    = (c_AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      F_IDLE  = 2'd0,
      F_REQ   = 2'd1,
      F_FLUSH = 2'd2
   } fetch_state_t;

   fetch_state_t     r_state;
   logic [c_HW-1:0]  r_hc;
   logic [c_VW-1:0]  r_vc;
   logic [c_WLW-1:0] r_words_left;
   logic [63:0]      r_mem [FIFO_DEPTH];
   logic [c_AW-1:0]  r_wr;
   logic [c_AW-1:0]  r_rd;
   logic [c_AW:0]    r_count;
   logic [2:0]       r_idx;

   logic        w_active;
   logic        w_flush_trig;
   logic        w_frame_pt;
   logic        w_tp;
   logic        w_tp_pix;
   logic [7:0]  w_tp_color;
   logic        w_pix_need;
   logic        w_empty;
   logic        w_full;
   logic        w_push;
   logic        w_pop;
   logic        w_clear;
   logic        w_underrun;
   logic        w_hs_n;
   logic        w_vs_n;
   logic [63:0] w_head;
   logic [7:0]  w_head_byte;

   assign w_active     = (r_hc < c_H_ACT) && (r_vc < c_V_ACT);
   assign w_flush_trig = ce_pix && (r_hc == '0) && (r_vc == c_V_ACT);
   assign w_frame_pt   = ce_pix && (r_hc == '0) && (r_vc == '0);
   assign w_hs_n       = !((r_hc >= c_HS_BEG) && (r_hc < c_HS_END));
   assign w_vs_n       = !((r_vc >= c_VS_BEG) && (r_vc < c_VS_END));

`ifdef FB_SCANOUT_TESTPAT_EN
   assign w_tp = test_pat;
`else
   logic w_unused_test_pat;
   assign w_unused_test_pat = test_pat;
   assign w_tp = 1'b0;
`endif

   assign w_tp_pix    = ce_pix && w_active && w_tp;
   assign w_tp_color  = r_hc[7:0] ^ r_vc[7:0];
   assign w_pix_need  = ce_pix && w_active && !w_tp;
   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == c_FULL);
   assign w_underrun  = w_pix_need && w_empty;
   assign w_head      = r_mem[r_rd];
   assign w_head_byte = w_head[{r_idx, 3'b000} +: 8];

   // A word that lands on the flush edge belongs to the old frame and is dropped.
   assign w_push  = (r_state == F_REQ) && fb_ready && !w_flush_trig;
   assign w_pop   = w_pix_need && !w_empty && (r_idx == 3'd7);
   assign w_clear = (r_state == F_FLUSH) && (!fb_req || fb_ready);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_hc <= '0;
         r_vc <= '0;
      end else if (ce_pix) begin
         if (r_hc == c_H_LAST) begin
            r_hc <= '0;
            r_vc <= (r_vc == c_V_LAST) ? '0 : r_vc + 1'b1;
         end else begin
            r_hc <= r_hc + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= F_IDLE;
         fb_req       <= 1'b0;
         fb_addr      <= '0;
         r_words_left <= c_WORDS_L;
      end else if (w_flush_trig) begin
         r_state <= F_FLUSH;
         if (fb_ready) begin
            fb_req <= 1'b0;
         end
      end else begin
         case (r_state)
            F_IDLE: begin
               if (!w_full && (r_words_left != '0)) begin
                  r_state <= F_REQ;
                  fb_req  <= 1'b1;
               end
            end
            F_REQ: begin
               if (fb_ready) begin
                  fb_addr      <= fb_addr + 28'd8;
                  r_words_left <= r_words_left - 1'b1;
                  fb_req       <= 1'b0;
                  r_state      <= F_IDLE;
               end
            end
            F_FLUSH: begin
               if (!fb_req || fb_ready) begin
                  fb_req       <= 1'b0;
                  fb_addr      <= '0;
                  r_words_left <= c_WORDS_L;
                  r_state      <= F_IDLE;
               end
            end
            default: r_state <= F_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else if (w_clear) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wr <= r_wr + 1'b1;
         end
         if (w_pop) begin
            r_rd <= r_rd + 1'b1;
         end
         r_count <= r_count + {{c_AW{1'b0}}, w_push} - {{c_AW{1'b0}}, w_pop};
      end
   end

   always_ff @(posedge clk_sys) begin
      if (w_push) begin
         r_mem[r_wr] <= fb_rdata;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         color       <= 8'h00;
         de          <= 1'b0;
         hs          <= 1'b1;
         vs          <= 1'b1;
         frame_start <= 1'b0;
         underflow   <= 1'b0;
         r_idx       <= 3'd0;
      end else begin
         frame_start <= w_frame_pt;
         if (w_clear) begin
            r_idx <= 3'd0;
         end else if (w_pix_need) begin
            r_idx <= r_idx + 3'd1;
         end
         if (ce_pix) begin
            de <= w_active;
            hs <= w_hs_n;
            vs <= w_vs_n;
            if (w_tp_pix) begin
               color <= w_tp_color;
            end else if (w_pix_need && !w_empty) begin
               color <= w_head_byte;
            end else begin
               color <= 8'h00;
            end
         end
         // An underrun on the very first pixel of a frame still registers.
         if (w_frame_pt) begin
            underflow <= w_underrun;
         end else if (w_underrun) begin
            underflow <= 1'b1;
         end
      end
   end

   a_no_push_when_full : assert property (@(posedge clk_sys) disable iff (!reset_n)
      !(w_push && w_full));

endmodule
`default_nettype wire

// File: tb/tb_fb_scanout.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_scanout
// Brief    : Self-checking bench for fb_scanout using reduced raster timing,
//            a randomized memory responder and a pixel-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fb_scanout;

   localparam int H_ACT  = 32;
   localparam int V_ACT  = 6;
   localparam int H_FP   = 4;
   localparam int H_SY   = 6;
   localparam int H_BP   = 6;
   localparam int V_FP   = 2;
   localparam int V_SY   = 2;
   localparam int V_BP   = 3;
   localparam int DEPTH  = 4;
   localparam int H_TOT  = H_ACT + H_FP + H_SY + H_BP;
   localparam int V_TOT  = V_ACT + V_FP + V_SY + V_BP;
   localparam int WORDS  = H_ACT * V_ACT / 8;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        ce_pix;
   logic [27:0] fb_addr;
   logic        fb_req;
   logic        fb_ready;
   logic [63:0] fb_rdata;
   logic        test_pat;
   logic [7:0]  color;
   logic        de;
   logic        hs;
   logic        vs;
   logic        frame_start;
   logic        underflow;

   typedef struct packed {
      logic [7:0] color;
      logic       de;
      logic       hs;
      logic       vs;
      logic       uf;
      logic       fs;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   logic run_en  = 1'b0;
   logic ce_d;
   int   cyc     = 0;

   // reference model state
   int   m_hc = 0, m_vc = 0;
   bit   m_uf = 0;
   bit   cfg_tp = 0, cfg_stall = 0;
   int   stall_n = 0;
   int   widx = 0;
   bit   req_old = 0;
   int   wait_cnt = -1;

   fb_scanout #(
      .H_ACTIVE   (H_ACT),
      .V_ACTIVE   (V_ACT),
      .H_FP       (H_FP),
      .H_SYNC     (H_SY),
      .H_BP       (H_BP),
      .V_FP       (V_FP),
      .V_SYNC     (V_SY),
      .V_BP       (V_BP),
      .FIFO_DEPTH (DEPTH)
   ) u_dut (
      .clk_sys     (clk_sys),
      .reset_n     (reset_n),
      .ce_pix      (ce_pix),
      .fb_addr     (fb_addr),
      .fb_req      (fb_req),
      .fb_ready    (fb_ready),
      .fb_rdata    (fb_rdata),
      .test_pat    (test_pat),
      .color       (color),
      .de          (de),
      .hs          (hs),
      .vs          (vs),
      .frame_start (frame_start),
      .underflow   (underflow)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Framebuffer contents as a function of linear pixel index.
   function automatic logic [7:0] pix_val(input int p);
      int v;
      v = (p * 37 + 11) % 256;
      return v[7:0];
   endfunction

   function automatic logic [63:0] word_at(input logic [27:0] a);
      logic [63:0] w;
      int          k;
      k = int'(a >> 3);
      for (int n = 0; n < 8; n++) w[8*n +: 8] = pix_val(k * 8 + n);
      return w;
   endfunction

   always @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) ce_d <= 1'b0;
      else          ce_d <= ce_pix;
   end

   // Stimulus, memory responder and expected-value producer.
   always @(negedge clk_sys) begin
      if (run_en) begin
         exp_t e;
         bit   act;
         bit   flush;
         int   p;
         int   exp_hs;
         fb_ready = 1'b0;
         cyc++;
         ce_pix = (cyc > 40) && ($urandom_range(0, 3) != 0);
         flush  = ce_pix && (m_hc == 0) && (m_vc == V_ACT);
         if (flush) begin
            exp_hs = cfg_tp ? DEPTH : (cfg_stall ? stall_n : WORDS);
            check("handshakes_per_frame", widx, exp_hs);
            if (fb_req) req_old = 1;
            widx      = 0;
            cfg_stall = 0;
`ifdef FB_SCANOUT_TESTPAT_EN
            cfg_tp   = ($urandom_range(0, 3) == 0);
            test_pat = cfg_tp;
`else
            cfg_tp   = 0;
            test_pat = 1'($urandom_range(0, 1));
`endif
            if (!cfg_tp && ($urandom_range(0, 2) == 0)) begin
               cfg_stall = 1;
               stall_n   = $urandom_range(1, WORDS - 1);
            end
         end
         if (fb_req) begin
            if (wait_cnt < 0) wait_cnt = $urandom_range(0, 2);
            if (!(cfg_stall && !req_old && (widx == stall_n))) begin
               if (wait_cnt == 0) begin
                  fb_ready = 1'b1;
                  fb_rdata = word_at(fb_addr);
                  if (req_old) begin
                     req_old = 0;
                  end else begin
                     check("fb_addr", int'(fb_addr), widx * 8);
                     widx++;
                  end
                  wait_cnt = -1;
               end else begin
                  wait_cnt--;
               end
            end
         end
         if (ce_pix) begin
            act      = (m_hc < H_ACT) && (m_vc < V_ACT);
            p        = m_vc * H_ACT + m_hc;
            e.color  = 8'h00;
            e.de     = act;
            e.hs     = !((m_hc >= H_ACT + H_FP) && (m_hc < H_ACT + H_FP + H_SY));
            e.vs     = !((m_vc >= V_ACT + V_FP) && (m_vc < V_ACT + V_FP + V_SY));
            e.fs     = (m_hc == 0) && (m_vc == 0);
            if (e.fs) m_uf = 0;
            if (act) begin
               if (cfg_tp)                             e.color = 8'(m_hc ^ m_vc);
               else if (cfg_stall && (p / 8 >= stall_n)) m_uf = 1;
               else                                    e.color = pix_val(p);
            end
            e.uf = m_uf;
            q.push_back(e);
            m_hc++;
            if (m_hc == H_TOT) begin
               m_hc = 0;
               m_vc = (m_vc == V_TOT - 1) ? 0 : m_vc + 1;
            end
         end
      end
   end

   // Monitor: one expected entry per pixel enable the DUT has consumed.
   always @(negedge clk_sys) begin
      if (reset_n && ce_d) begin
         if (q.size() == 0) begin
            check("scoreboard_entry_present", 0, 1);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("color", color, e.color);
            check("de", de, e.de);
            check("hs", hs, e.hs);
            check("vs", vs, e.vs);
            check("underflow", underflow, e.uf);
            check("frame_start", frame_start, e.fs);
         end
      end else if (reset_n && run_en) begin
         check("frame_start_idle", frame_start, 0);
      end
   end

   initial begin
      bit got;
      reset_n  = 1'b0;
      ce_pix   = 1'b0;
      fb_ready = 1'b0;
      fb_rdata = '0;
      test_pat = 1'b0;
      repeat (3) @(negedge clk_sys);
      check("rst_fb_addr", int'(fb_addr), 0);
      check("rst_fb_req", fb_req, 0);
      check("rst_color", color, 0);
      check("rst_de", de, 0);
      check("rst_hs", hs, 1);
      check("rst_vs", vs, 1);
      check("rst_frame_start", frame_start, 0);
      check("rst_underflow", underflow, 0);
      reset_n = 1'b1;
      run_en  = 1'b1;
      repeat (8000) @(posedge clk_sys);

      got = 0;
      for (int i = 0; i < 3000 && !got; i++) begin
         @(posedge clk_sys);
         #1;
         if (fb_req) got = 1;
      end
      check("request_seen_before_reset", got, 1);
      run_en   = 1'b0;
      ce_pix   = 1'b0;
      fb_ready = 1'b0;
      repeat (3) @(posedge clk_sys);
      check("scoreboard_drained", q.size(), 0);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_fb_req", fb_req, 0);
      check("async_rst_fb_addr", int'(fb_addr), 0);
      check("async_rst_hs", hs, 1);
      check("async_rst_vs", vs, 1);
      check("async_rst_de", de, 0);
      check("async_rst_underflow", underflow, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
